// File: rtl/lif_pkg.sv
// Shared types and defaults for the time-multiplexed LIF neuron scheduler.
package lif_pkg;
  localparam int DATA_W          = 8;
  localparam int DEF_THRESHOLD   = 128;
  localparam int DEF_DECAY_SHIFT = 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    DONE  = 2'd2
  } lif_state_e;
endpackage

// File: rtl/spike_fifo.sv
// Spike-event FIFO: push lands in 1 cycle, head visible when o_pop_vld is high.
// Pop on o_pop_vld & i_pop_rdy; pushes while full are dropped, so the producer must watch o_full.
module spike_fifo #(
  parameter int WIDTH = 2,
  parameter int DEPTH = 2
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_push_vld,
  input  logic [WIDTH-1:0] i_push_dat,
  output logic             o_pop_vld,
  input  logic             i_pop_rdy,
  output logic [WIDTH-1:0] o_pop_dat,
  output logic             o_full
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] L_DEPTH = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_cnt;
  logic             w_push;
  logic             w_pop;

  assign o_full    = (r_cnt == L_DEPTH);
  assign o_pop_vld = (r_cnt != '0);
  assign o_pop_dat = r_mem[r_rd_ptr];
  assign w_push    = i_push_vld && !o_full;
  assign w_pop     = o_pop_vld && i_pop_rdy;

  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_push_dat;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt    <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + (AW+1)'(1);
        2'b01:   r_cnt <= r_cnt - (AW+1)'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end
endmodule

// File: rtl/lif_tdm_scheduler.sv
// One LIF datapath swept over NUM_NEURONS neurons per tick, 1 neuron/cycle, done NUM_NEURONS+1 cycles after tick.
// A full spike FIFO stalls the sweep (idx holds) until the consumer drains an event.
module lif_tdm_scheduler
  import lif_pkg::*;
#(
  parameter int NUM_NEURONS = 4,
  parameter int ID_W        = $clog2(NUM_NEURONS),
  parameter int THRESHOLD   = DEF_THRESHOLD,
  parameter int DECAY_SHIFT = DEF_DECAY_SHIFT,
  parameter int FIFO_DEPTH  = 2
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_cur_we,
  input  logic [ID_W-1:0]   i_cur_addr,
  input  logic [DATA_W-1:0] i_cur_data,
  input  logic              i_tick,
  output logic              o_spk_valid,
  input  logic              i_spk_ready,
  output logic [ID_W-1:0]   o_spk_id,
  input  logic [ID_W-1:0]   i_mon_addr,
  output logic [DATA_W-1:0] o_mon_state,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_overrun
);
  localparam logic [DATA_W-1:0] L_THR  = DATA_W'(THRESHOLD);
  localparam logic [ID_W-1:0]   L_LAST = ID_W'(NUM_NEURONS - 1);

  lif_state_e        r_state;
  lif_state_e        w_next;
  logic [ID_W-1:0]   r_idx;
  logic [DATA_W-1:0] r_st  [NUM_NEURONS];
  logic [DATA_W-1:0] r_cur [NUM_NEURONS];
  logic [DATA_W-1:0] r_mon;
  logic              r_overrun;

  logic [DATA_W-1:0] w_s;
  logic [DATA_W-1:0] w_c;
  logic [DATA_W-1:0] w_dec;
  logic [DATA_W:0]   w_sum;
  logic [DATA_W-1:0] w_sat;
  logic              w_fire;
  logic              w_full;
  logic              w_upd;

  // Reads the current register before any same-cycle write lands.
  assign w_s    = r_st[r_idx];
  assign w_c    = r_cur[r_idx];
  assign w_dec  = w_s - (w_s >> DECAY_SHIFT);
  assign w_sum  = {1'b0, w_dec} + {1'b0, w_c};
  assign w_sat  = w_sum[DATA_W] ? '1 : w_sum[DATA_W-1:0];
  assign w_fire = (w_sat >= L_THR);
  assign w_upd  = (r_state == SWEEP) && !w_full;

  assign o_mon_state = r_mon;
  assign o_overrun   = r_overrun;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state   <= IDLE;
      r_idx     <= '0;
      r_mon     <= '0;
      r_overrun <= 1'b0;
      for (int i = 0; i < NUM_NEURONS; i++) begin
        r_st[i]  <= '0;
        r_cur[i] <= '0;
      end
    end else begin
      r_state <= w_next;
      if (i_tick && (r_state != IDLE)) r_overrun <= 1'b1;
      if (w_upd) begin
        r_st[r_idx] <= w_fire ? '0 : w_sat;
        r_idx       <= (r_idx == L_LAST) ? '0 : r_idx + ID_W'(1);
      end
      if (i_cur_we) r_cur[i_cur_addr] <= i_cur_data;
      r_mon <= r_st[i_mon_addr];
    end
  end

  always_comb begin
    w_next = r_state;
    o_busy = 1'b0;
    o_done = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_tick) w_next = SWEEP;
      end
      SWEEP: begin
        o_busy = 1'b1;
        if (w_upd && (r_idx == L_LAST)) w_next = DONE;
      end
      DONE: begin
        o_busy = 1'b1;
        o_done = 1'b1;
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  spike_fifo #(
    .WIDTH (ID_W),
    .DEPTH (FIFO_DEPTH)
  ) u_spike_fifo (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_push_vld (w_upd && w_fire),
    .i_push_dat (r_idx),
    .o_pop_vld  (o_spk_valid),
    .i_pop_rdy  (i_spk_ready),
    .o_pop_dat  (o_spk_id),
    .o_full     (w_full)
  );
endmodule

// File: tb/tb_lif_tdm_scheduler.sv
// Directed bench: default-threshold DUT plus a THRESHOLD=255 twin sharing the same inputs.
module tb_lif_tdm_scheduler;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cur_we = 1'b0;
  logic [1:0] cur_addr = '0;
  logic [7:0] cur_data = '0;
  logic       tick = 1'b0;
  logic       spk_ready = 1'b1;
  logic [1:0] mon_addr = '0;

  logic       spk_valid, busy, done, overrun;
  logic [1:0] spk_id;
  logic [7:0] mon_state;
  logic       spk_valid_b, busy_b, done_b, overrun_b;
  logic [1:0] spk_id_b;
  logic [7:0] mon_state_b;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  logic [1:0] evq[$];
  logic [1:0] evq_b[$];

  always #5 clk = ~clk;

  lif_tdm_scheduler dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_cur_we(cur_we), .i_cur_addr(cur_addr),
    .i_cur_data(cur_data), .i_tick(tick), .o_spk_valid(spk_valid),
    .i_spk_ready(spk_ready), .o_spk_id(spk_id), .i_mon_addr(mon_addr),
    .o_mon_state(mon_state), .o_busy(busy), .o_done(done), .o_overrun(overrun)
  );

  lif_tdm_scheduler #(.THRESHOLD(255)) dut_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_cur_we(cur_we), .i_cur_addr(cur_addr),
    .i_cur_data(cur_data), .i_tick(tick), .o_spk_valid(spk_valid_b),
    .i_spk_ready(spk_ready), .o_spk_id(spk_id_b), .i_mon_addr(mon_addr),
    .o_mon_state(mon_state_b), .o_busy(busy_b), .o_done(done_b), .o_overrun(overrun_b)
  );

  // Record accepted events and done pulses at the falling edge, where inputs are stable.
  always @(negedge clk) begin
    if (rst_n && spk_valid && spk_ready) evq.push_back(spk_id);
    if (rst_n && spk_valid_b && spk_ready) evq_b.push_back(spk_id_b);
    if (done) done_cnt++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; tick = 1'b0; cur_we = 1'b0; spk_ready = 1'b1;
    step(); step();
    rst_n = 1'b1;
  endtask

  task automatic wr_cur(input logic [1:0] a, input logic [7:0] d);
    cur_we = 1'b1; cur_addr = a; cur_data = d;
    step();
    cur_we = 1'b0;
  endtask

  task automatic tick_pulse();
    tick = 1'b1;
    step();
    tick = 1'b0;
  endtask

  task automatic wait_done(input int bound, output int n, output bit seen);
    n = 0; seen = 1'b0;
    while (n < bound && !seen) begin
      step();
      n++;
      if (done) seen = 1'b1;
    end
  endtask

  task automatic read_mon(input logic [1:0] a, output logic [7:0] va, output logic [7:0] vb);
    mon_addr = a;
    step();
    va = mon_state;
    vb = mon_state_b;
  endtask

  task automatic test_reset();
    logic [7:0] va, vb;
    rst_n = 1'b0;
    step(); step();
    if (spk_valid !== 1'b0) begin errors++; $display("FAIL reset_spk_valid: got %b want 0", spk_valid); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
    checks++;
    if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun: got %b want 0", overrun); end
    checks++;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      read_mon(2'(i), va, vb);
      if (va !== 8'd0) begin errors++; $display("FAIL reset_state[%0d]: got %0d want 0", i, va); end
      checks++;
    end
  endtask

  task automatic test_leak_fire();
    int n, be, bd;
    bit seen;
    logic [7:0] va, vb;
    do_reset();
    be = evq.size(); bd = done_cnt;
    wr_cur(2'd0, 8'd100);
    tick_pulse();
    wait_done(12, n, seen);
    if (!seen || n != 4) begin errors++; $display("FAIL leak_done_latency: got seen=%0d after %0d cycles want seen=1 after 4", seen, n); end
    checks++;
    step();
    if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL leak_done_pulse: got busy=%b done=%b want 0 0", busy, done); end
    checks++;
    read_mon(2'd0, va, vb);
    if (va !== 8'd100) begin errors++; $display("FAIL leak_first_state: got %0d want 100", va); end
    checks++;
    if (evq.size() != be) begin errors++; $display("FAIL leak_no_event: got %0d events want 0", evq.size() - be); end
    checks++;
    tick_pulse();
    wait_done(12, n, seen);
    step(); step();
    if (evq.size() != be + 1) begin errors++; $display("FAIL leak_fire_count: got %0d events want 1", evq.size() - be); end
    else if (evq[be] !== 2'd0) begin errors++; $display("FAIL leak_fire_id: got %0d want 0", evq[be]); end
    checks++;
    read_mon(2'd0, va, vb);
    if (va !== 8'd0) begin errors++; $display("FAIL leak_fire_state: got %0d want 0", va); end
    checks++;
    if (done_cnt - bd != 2) begin errors++; $display("FAIL leak_done_count: got %0d want 2", done_cnt - bd); end
    checks++;
  endtask

  task automatic test_threshold_edge();
    int n, be;
    bit seen;
    logic [7:0] va, vb;
    do_reset();
    be = evq.size();
    wr_cur(2'd2, 8'd127);
    tick_pulse();
    wait_done(12, n, seen);
    step();
    read_mon(2'd2, va, vb);
    if (va !== 8'd127 || evq.size() != be) begin errors++; $display("FAIL thr_below: got state=%0d events=%0d want 127 0", va, evq.size() - be); end
    checks++;
    wr_cur(2'd2, 8'd64);
    tick_pulse();
    wait_done(12, n, seen);
    step(); step();
    if (evq.size() != be + 1) begin errors++; $display("FAIL thr_equal_count: got %0d events want 1", evq.size() - be); end
    else if (evq[be] !== 2'd2) begin errors++; $display("FAIL thr_equal_id: got %0d want 2", evq[be]); end
    checks++;
    read_mon(2'd2, va, vb);
    if (va !== 8'd0) begin errors++; $display("FAIL thr_equal_state: got %0d want 0", va); end
    checks++;
  endtask

  task automatic test_saturation();
    int n, be, bb;
    bit seen;
    logic [7:0] va, vb;
    do_reset();
    be = evq.size(); bb = evq_b.size();
    wr_cur(2'd1, 8'd100);
    tick_pulse();
    wait_done(12, n, seen);
    step();
    read_mon(2'd1, va, vb);
    if (va !== 8'd100 || vb !== 8'd100) begin errors++; $display("FAIL sat_setup: got a=%0d b=%0d want 100 100", va, vb); end
    checks++;
    wr_cur(2'd1, 8'd255);
    tick_pulse();
    wait_done(12, n, seen);
    step(); step();
    if (evq.size() != be + 1) begin errors++; $display("FAIL sat_count: got %0d events want 1", evq.size() - be); end
    else if (evq[be] !== 2'd1) begin errors++; $display("FAIL sat_id: got %0d want 1", evq[be]); end
    checks++;
    if (evq_b.size() != bb + 1) begin errors++; $display("FAIL sat255_count: got %0d events want 1", evq_b.size() - bb); end
    else if (evq_b[bb] !== 2'd1) begin errors++; $display("FAIL sat255_id: got %0d want 1", evq_b[bb]); end
    checks++;
    read_mon(2'd1, va, vb);
    if (va !== 8'd0 || vb !== 8'd0) begin errors++; $display("FAIL sat_state: got a=%0d b=%0d want 0 0", va, vb); end
    checks++;
  endtask

  task automatic test_backpressure();
    int n, be, bd;
    bit seen;
    logic [7:0] va, vb;
    do_reset();
    for (int i = 0; i < 4; i++) wr_cur(2'(i), 8'd200);
    spk_ready = 1'b0;
    be = evq.size(); bd = done_cnt;
    tick_pulse();
    repeat (10) step();
    if (busy !== 1'b1 || done_cnt != bd) begin errors++; $display("FAIL bp_stalled: got busy=%b dones=%0d want 1 0", busy, done_cnt - bd); end
    checks++;
    if (spk_valid !== 1'b1 || spk_id !== 2'd0) begin errors++; $display("FAIL bp_head: got valid=%b id=%0d want 1 0", spk_valid, spk_id); end
    checks++;
    spk_ready = 1'b1;
    wait_done(20, n, seen);
    if (!seen) begin errors++; $display("FAIL bp_done: got no done within %0d cycles want done", n); end
    checks++;
    repeat (3) step();
    if (evq.size() != be + 4) begin errors++; $display("FAIL bp_count: got %0d events want 4", evq.size() - be); end
    else begin
      for (int i = 0; i < 4; i++) begin
        if (evq[be + i] !== 2'(i)) begin errors++; $display("FAIL bp_order[%0d]: got %0d want %0d", i, evq[be + i], i); end
        checks++;
      end
    end
    checks++;
    read_mon(2'd3, va, vb);
    if (va !== 8'd0 || vb !== 8'd200) begin errors++; $display("FAIL bp_state3: got a=%0d b=%0d want 0 200", va, vb); end
    checks++;
  endtask

  task automatic test_overrun();
    int bd;
    logic [7:0] va, vb;
    do_reset();
    if (overrun !== 1'b0) begin errors++; $display("FAIL ovr_clear: got %b want 0", overrun); end
    checks++;
    wr_cur(2'd0, 8'd100);
    bd = done_cnt;
    tick_pulse();
    step();
    tick_pulse();
    if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_set: got %b want 1", overrun); end
    checks++;
    repeat (12) step();
    if (done_cnt - bd != 1) begin errors++; $display("FAIL ovr_done_count: got %0d want 1", done_cnt - bd); end
    checks++;
    read_mon(2'd0, va, vb);
    if (va !== 8'd100) begin errors++; $display("FAIL ovr_state: got %0d want 100", va); end
    checks++;
    if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_sticky: got %b want 1", overrun); end
    checks++;
  endtask

  task automatic test_reset_mid();
    int n, bd, be;
    bit seen;
    logic [7:0] va, vb;
    do_reset();
    wr_cur(2'd1, 8'd100);
    tick_pulse();
    wait_done(12, n, seen);
    step();
    wr_cur(2'd0, 8'd200);
    spk_ready = 1'b0;
    bd = done_cnt;
    tick_pulse();
    step();
    if (spk_valid !== 1'b1) begin errors++; $display("FAIL mid_event_queued: got %b want 1", spk_valid); end
    checks++;
    rst_n = 1'b0;
    step(); step();
    rst_n = 1'b1;
    spk_ready = 1'b1;
    if (spk_valid !== 1'b0 || busy !== 1'b0 || overrun !== 1'b0) begin
      errors++; $display("FAIL mid_outputs: got valid=%b busy=%b ovr=%b want 0 0 0", spk_valid, busy, overrun);
    end
    checks++;
    read_mon(2'd1, va, vb);
    if (va !== 8'd0) begin errors++; $display("FAIL mid_state1: got %0d want 0", va); end
    checks++;
    repeat (6) step();
    if (done_cnt != bd) begin errors++; $display("FAIL mid_no_done: got %0d dones want 0", done_cnt - bd); end
    checks++;
    be = evq.size();
    wr_cur(2'd0, 8'd100);
    tick_pulse();
    wait_done(12, n, seen);
    if (!seen || n != 4) begin errors++; $display("FAIL mid_clean_latency: got seen=%0d after %0d want seen=1 after 4", seen, n); end
    checks++;
    step();
    read_mon(2'd0, va, vb);
    if (va !== 8'd100 || evq.size() != be) begin errors++; $display("FAIL mid_clean_sweep: got s0=%0d events=%0d want 100 0", va, evq.size() - be); end
    checks++;
  endtask

  initial begin
    test_reset();
    test_leak_fire();
    test_threshold_edge();
    test_saturation();
    test_backpressure();
    test_overrun();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
